// File: rtl/fmul_pipe_hs.sv
// rtl/fmul_pipe_hs.sv - pipelined RNE floating-point multiplier with valid/ready and tag side-band (optional IEEE specials: FMUL_IEEE_SPECIALS_EN)
module fmul_pipe_hs #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     x,
    input  logic [EXP_W+MAN_W:0]     y,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     res,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     ovf,
    output logic                     unf
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}} | (W'(1) << (MAN_W - 1));

    // Stage valids and the handshake advance chain.
    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] adv;
    logic               accept;

    // Stage 0 holds the raw product; exponents are two's complement in EW bits.
    logic              s0_sign;
    logic [EW-1:0]     s0_exp;
    logic [PW-1:0]     s0_prod;
    logic              s0_zero;
    logic              s0_nan;
    logic              s0_inf;
    logic [TAG_W-1:0]  s0_tag;

    // Stages 1..LATENCY-1 hold finished results; the last one drives the outputs.
    logic [W-1:0]      res_q [1:LATENCY-1];
    logic [TAG_W-1:0]  tag_q [1:LATENCY-1];
    logic              ovf_q [1:LATENCY-1];
    logic              unf_q [1:LATENCY-1];

    // Operand decode for stage 0.
    logic [EXP_W-1:0]  ex, ey;
    logic [MAN_W-1:0]  mx, my;
    logic [PW-1:0]     prod_c;
    logic [EW-1:0]     exp_c;
    logic              zero_c, nan_c, inf_c;

    // Normalise / round results for stage 1.
    logic              top;
    logic [MAN_W-1:0]  frac;
    logic              guard, sticky, rup;
    logic [MAN_W:0]    frac_r;
    logic [EW-1:0]     exp_r;
    logic              ovf_cond, unf_cond;
    logic [W-1:0]      r_res;
    logic              r_ovf, r_unf;

    // A stage may move when it, or any stage downstream of it, has room (or the consumer takes the head).
    always_comb begin
        logic chain;
        adv   = '0;
        chain = out_ready;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            chain  = chain | ~v[k];
            adv[k] = chain;
        end
    end

    assign in_ready = rstn & adv[0];
    assign accept   = in_valid & in_ready;

    // Operand unpacking, exact mantissa product and biased exponent sum, plus input classification.
    always_comb begin
        ex     = x[W-2:MAN_W];
        ey     = y[W-2:MAN_W];
        mx     = x[MAN_W-1:0];
        my     = y[MAN_W-1:0];
        prod_c = PW'({1'b1, mx}) * PW'({1'b1, my});
        exp_c  = EW'(ex) + EW'(ey) - EW'(BIAS);
`ifdef FMUL_IEEE_SPECIALS_EN
        begin
            logic x_max, y_max, x_z, y_z, x_nan, y_nan, x_inf, y_inf;
            x_max  = &ex;
            y_max  = &ey;
            x_z    = ~|ex;
            y_z    = ~|ey;
            x_nan  = x_max & (|mx);
            y_nan  = y_max & (|my);
            x_inf  = x_max & ~(|mx);
            y_inf  = y_max & ~(|my);
            nan_c  = x_nan | y_nan | (x_inf & y_z) | (y_inf & x_z);
            inf_c  = ~nan_c & (x_inf | y_inf);
            zero_c = ~nan_c & ~inf_c & (x_z | y_z);
        end
`else
        nan_c  = 1'b0;
        inf_c  = 1'b0;
        zero_c = ~(|ex) | ~(|ey);
`endif
    end

    // Normalise the product, round to nearest even, then pick special/overflow/underflow/normal result.
    always_comb begin
        top    = s0_prod[PW-1];
        frac   = top ? s0_prod[PW-2:MAN_W+1] : s0_prod[PW-3:MAN_W];
        guard  = top ? s0_prod[MAN_W] : s0_prod[MAN_W-1];
        sticky = top ? |s0_prod[MAN_W-1:0] : |s0_prod[MAN_W-2:0];
        rup    = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + (MAN_W + 1)'(rup);
        exp_r  = s0_exp + EW'(top) + EW'(frac_r[MAN_W]);
        ovf_cond = ~exp_r[EW-1] & (exp_r >= EW'(EMAX));
        unf_cond = exp_r[EW-1] | (exp_r == '0);
        r_res  = '0;
        r_ovf  = 1'b0;
        r_unf  = 1'b0;
        if (s0_nan) begin
            r_res = QNAN;
        end else if (s0_inf) begin
            r_res = {s0_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s0_zero) begin
            r_res = '0;
        end else if (ovf_cond) begin
            r_res = {s0_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_ovf = 1'b1;
        end else if (unf_cond) begin
            r_unf = 1'b1;
        end else begin
            r_res = {s0_sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
        end
    end

    // Valid chain and stage-0 capture; data registers only load when a real op moves in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v       <= '0;
            s0_sign <= 1'b0;
            s0_exp  <= '0;
            s0_prod <= '0;
            s0_zero <= 1'b0;
            s0_nan  <= 1'b0;
            s0_inf  <= 1'b0;
            s0_tag  <= '0;
        end else begin
            if (adv[0]) begin
                v[0] <= accept;
                if (accept) begin
                    s0_sign <= x[W-1] ^ y[W-1];
                    s0_exp  <= exp_c;
                    s0_prod <= prod_c;
                    s0_zero <= zero_c;
                    s0_nan  <= nan_c;
                    s0_inf  <= inf_c;
                    s0_tag  <= in_tag;
                end
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (adv[k])
                    v[k] <= v[k-1];
            end
        end
    end

    // Result stages: stage 1 captures the rounded result, later stages are plain retiming registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 1; k < LATENCY; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
                ovf_q[k] <= 1'b0;
                unf_q[k] <= 1'b0;
            end
        end else begin
            if (adv[1] && v[0]) begin
                res_q[1] <= r_res;
                tag_q[1] <= s0_tag;
                ovf_q[1] <= r_ovf;
                unf_q[1] <= r_unf;
            end
            for (int k = 2; k < LATENCY; k++) begin
                if (adv[k] && v[k-1]) begin
                    res_q[k] <= res_q[k-1];
                    tag_q[k] <= tag_q[k-1];
                    ovf_q[k] <= ovf_q[k-1];
                    unf_q[k] <= unf_q[k-1];
                end
            end
        end
    end

    assign out_valid = v[LATENCY-1];
    assign res       = res_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign ovf       = ovf_q[LATENCY-1];
    assign unf       = unf_q[LATENCY-1];

endmodule

// File: tb/tb_fmul_pipe_hs.sv
// tb/tb_fmul_pipe_hs.sv - directed self-checking bench for fmul_pipe_hs at LATENCY 2 and 4
module tb_fmul_pipe_hs;
    localparam int NV = 17;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        iv  [2];
    logic        ir  [2];
    logic [31:0] xa  [2];
    logic [31:0] ya  [2];
    logic [4:0]  ti  [2];
    logic        ov  [2];
    logic        orr [2];
    logic [31:0] ra  [2];
    logic [4:0]  to  [2];
    logic        of  [2];
    logic        uf  [2];

    fmul_pipe_hs #(.EXP_W(8), .MAN_W(23), .LATENCY(2), .TAG_W(5)) u_dut2 (
        .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]), .x(xa[0]), .y(ya[0]),
        .in_tag(ti[0]), .out_valid(ov[0]), .out_ready(orr[0]), .res(ra[0]), .out_tag(to[0]),
        .ovf(of[0]), .unf(uf[0])
    );

    fmul_pipe_hs #(.EXP_W(8), .MAN_W(23), .LATENCY(4), .TAG_W(5)) u_dut4 (
        .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]), .x(xa[1]), .y(ya[1]),
        .in_tag(ti[1]), .out_valid(ov[1]), .out_ready(orr[1]), .res(ra[1]), .out_tag(to[1]),
        .ovf(of[1]), .unf(uf[1])
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vr [NV];
    logic        vo [NV];
    logic        vu [NV];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setv(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic o, input logic u);
        va[i] = a; vb[i] = b; vr[i] = r; vo[i] = o; vu[i] = u;
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] er, input logic eo, input logic eu, input int lat_exp);
        int n;
        @(negedge clk);
        xa[d] = a; ya[d] = b; ti[d] = t; iv[d] = 1'b1; orr[d] = 1'b1;
        #1 chk("in_ready", ir[d], 1);
        @(posedge clk);
        #1 iv[d] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov[d] && n < 20);
        chk("latency", n, lat_exp);
        chk("res", ra[d], er);
        chk("tag", to[d], t);
        chk("ovf", of[d], eo);
        chk("unf", uf[d], eu);
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int d);
        logic [31:0] sx [6];
        logic [31:0] se [6];
        logic [31:0] pres;
        logic [4:0]  ptag;
        logic        pstall, acc, saw_low;
        int          rx, c, k;
        sx = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h3FA00000};
        se = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40C00000, 32'h3F800000, 32'h40200000};
        saw_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    xa[d] = sx[i]; ya[d] = 32'h40000000; ti[d] = 5'(i); iv[d] = 1'b1;
                    k = 0;
                    acc = 1'b0;
                    while (1) begin
                        #1 acc = ir[d];
                        if (acc || k >= 100) break;
                        saw_low = 1'b1;
                        k++;
                        @(negedge clk);
                    end
                    if (!acc) chk("accept_timeout", 0, 1);
                    @(posedge clk);
                end
                @(negedge clk);
                iv[d] = 1'b0;
            end
            begin
                rx = 0; c = 0; pstall = 1'b0; pres = '0; ptag = '0;
                while (rx < 6 && c < 200) begin
                    @(negedge clk);
                    orr[d] = !(c >= 5 && c <= 8);
                    if (pstall) begin
                        chk("stall_valid", ov[d], 1);
                        chk("stall_res", ra[d], pres);
                        chk("stall_tag", to[d], ptag);
                    end
                    if (ov[d] && orr[d]) begin
                        chk("order_tag", to[d], rx);
                        chk("order_res", ra[d], se[rx]);
                        rx++;
                    end
                    pstall = ov[d] & ~orr[d];
                    pres = ra[d];
                    ptag = to[d];
                    c++;
                end
                orr[d] = 1'b1;
                chk("stream_count", rx, 6);
            end
        join
        chk("in_ready_fell", saw_low, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic stale;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; xa[d] = '0; ya[d] = '0; ti[d] = '0; orr[d] = 1'b1;
        end
        setv(0,  32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        setv(1,  32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0);
        setv(2,  32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0);
        setv(3,  32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
        setv(4,  32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1, 1'b0);
        setv(5,  32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1);
        setv(6,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        setv(7,  32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
        setv(8,  32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0);
        setv(9,  32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0);
        setv(10, 32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0);
        setv(11, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0);
        setv(12, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0);
`ifdef FMUL_IEEE_SPECIALS_EN
        setv(13, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0);
        setv(14, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0);
        setv(15, 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0);
        setv(16, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);
`else
        setv(13, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0);
        setv(14, 32'h7F800000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
        setv(15, 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1, 1'b0);
        setv(16, 32'h7FC00000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0);
`endif

        rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", ov[d], 0);
            chk("rst_in_ready", ir[d], 0);
            chk("rst_res", ra[d], 0);
            chk("rst_flags", {of[d], uf[d], to[d]}, 0);
        end
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++)
            run_op(0, va[i], vb[i], 5'(i), vr[i], vo[i], vu[i], 2);
        run_op(1, va[0], vb[0], 5'd9, vr[0], vo[0], vu[0], 4);

        stream(0);
        stream(1);

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            xa[d] = 32'h3FC00000; ya[d] = 32'h40000000; ti[d] = 5'd3; iv[d] = 1'b1; orr[d] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) ti[d] = 5'd4;
        @(posedge clk);
        #1 for (int d = 0; d < 2; d++) iv[d] = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", ov[0], 1);
        #2 rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_valid", ov[d], 0);
            chk("async_rst_res", ra[d], 0);
            chk("async_rst_tag", to[d], 0);
            chk("async_rst_in_ready", ir[d], 0);
        end
        @(negedge clk);
        rstn = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ov[0] || ov[1]) stale = 1'b1;
        end
        chk("no_stale_after_rst", stale, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
